decoder_2x4_grant: RTL
======================

DECODER_2X4_GRANT -- requirements
Module: decoder_2x4_grant

Interface
REQ-001 SHALL have parameter HOLD_CYCLES, default 3, number of clock periods the one-hot grant is held; legal range 1..15.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on the rising edge.
REQ-003 SHALL have port nrst  input  1  reset, synchronous and active-low; sampled only on the rising edge of clk.
REQ-004 SHALL have port Y  input  2  encoded index from the priority encoder; Y=3 denotes D[3], the highest priority.
REQ-005 SHALL have port V  input  1  request valid; Y is meaningful only while V=1.
REQ-006 SHALL have port ready  output  1  block can accept a request this cycle.
REQ-007 SHALL have port D  output  4  registered one-hot grant; D[Y] set during grant.
REQ-008 SHALL have port busy  output  1  high while a grant is in progress (GRANT or DONE state).
REQ-009 SHALL have port done  output  1  single-cycle pulse marking grant completion.

Function
REQ-010 SHALL implement three states: IDLE, GRANT, DONE; every output SHALL be a function of registered state only, with no combinational path from Y/V to any output.
REQ-011 In IDLE: ready=1, D=0000, busy=0, done=0.
REQ-012 Handshake: a request SHALL be accepted on a rising edge where V=1 and ready=1; Y SHALL be latched on that edge.
REQ-013 On acceptance: next state GRANT; D=onehot(latched Y), busy=1, ready=0 from the following cycle; hold counter (4 bits) loaded with HOLD_CYCLES-1.
REQ-014 In GRANT: D SHALL stay constant for exactly HOLD_CYCLES clock periods; counter decrements by 1 each edge; at counter=0 the next state SHALL be DONE.
REQ-015 In DONE: D=0000, done=1, busy=1, ready=0 for exactly one cycle; next state SHALL be IDLE unconditionally.
REQ-016 Changes on Y or V while in GRANT or DONE SHALL be ignored: no effect on D, counter or state, and no request queued.
REQ-017 V=1 held continuously SHALL produce back-to-back transactions; period = HOLD_CYCLES+2 cycles (1 IDLE accept cycle, HOLD_CYCLES grant cycles, 1 DONE cycle).
REQ-018 V=0 in IDLE SHALL leave state unchanged; the Y value SHALL be don't-care.
REQ-019 D SHALL never have more than one bit set; D SHALL be 0000 outside GRANT.
REQ-020 HOLD_CYCLES=1 SHALL yield a one-cycle grant; the counter SHALL never wrap below 0.
REQ-021 Unreachable state encodings SHALL transition to IDLE on the next edge.

Reset
REQ-022 When nrst=0 on a rising edge: state IDLE, counter 0, latched Y 00, D=0000, busy=0, done=0, ready=1 after that edge.
REQ-023 Reset asserted mid-GRANT or in DONE SHALL abort the transaction without a done pulse; the in-flight request SHALL be discarded.
REQ-024 Reset SHALL take priority over acceptance; V=1 during reset SHALL NOT be accepted.
REQ-025 Reset SHALL take effect only at a clock edge; an nrst pulse falling and rising between edges SHALL have no effect.

Verification (HOLD_CYCLES=3, 10 ns clock)
REQ-026 Reset then idle: nrst=0 for 2 edges, then nrst=1, V=0 -> D=0000, ready=1, busy=0, done=0 on every cycle.
REQ-027 Single request: V=1, Y=10 for one cycle while ready=1 -> D=0100 for exactly 3 cycles, then D=0000 with done=1 for 1 cycle, then ready=1.
REQ-028 Sweep: for Y=00..11, each accepted in turn -> D=0001, 0010, 0100, 1000 respectively; each grant 3 cycles long.
REQ-029 Ignore while busy: accept Y=01, then drive Y=11, V=1 during GRANT -> D stays 0010 for its 3 cycles; Y=11 is sampled only at the next IDLE accept edge.
REQ-030 Reset mid-grant: accept Y=11, assert nrst=0 at the 2nd grant cycle -> D=0000, done stays 0, ready=1 after that edge.
REQ-031 Continuous V=1, Y=00 for 20 cycles -> grants of 0001 repeat with a 5-cycle period; the checker SHALL confirm one-hot or zero on D on every cycle.

Source files
------------

// File: rtl/decoder_2x4_grant.sv
// Registered 2-to-4 grant decoder. Latches an encoded request index on a
// valid/ready handshake, holds the matching one-hot grant for HOLD_CYCLES
// clock periods, then pulses done for one cycle before returning to idle.
// All outputs come straight from flops; Y/V only influence next state.
module decoder_2x4_grant #(
  parameter int unsigned HOLD_CYCLES = 3  // legal range 1..15
) (
  input  logic       clk,
  input  logic       nrst,
  input  logic [1:0] Y,
  input  logic       V,
  output logic       ready,
  output logic [3:0] D,
  output logic       busy,
  output logic       done
);

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StGrant = 2'd1,
    StDone  = 2'd2
  } state_e;

  // Counter reload: a grant of N cycles counts N-1 down to 0.
  localparam logic [3:0] CntLoad = 4'(HOLD_CYCLES - 1);

  state_e     r_state;
  logic [3:0] r_cnt;
  logic [1:0] r_y;
  logic       r_ready;
  logic [3:0] r_d;
  logic       r_busy;
  logic       r_done;

  logic       w_accept;
  logic [3:0] w_onehot;

  // Acceptance qualifies on the registered ready, so a request is only
  // taken while idle; anything seen in GRANT/DONE is dropped.
  assign w_accept = V & r_ready;
  assign w_onehot = 4'b0001 << Y;

  // State, hold counter, latched index and registered outputs.
  always_ff @(posedge clk) begin
    if (!nrst) begin
      r_state <= StIdle;
      r_cnt   <= 4'd0;
      r_y     <= 2'd0;
      r_ready <= 1'b1;
      r_d     <= 4'b0000;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      case (r_state)
        StIdle: begin
          if (w_accept) begin
            r_state <= StGrant;
            r_cnt   <= CntLoad;
            r_y     <= Y;
            r_ready <= 1'b0;
            r_d     <= w_onehot;
            r_busy  <= 1'b1;
            r_done  <= 1'b0;
          end
        end
        StGrant: begin
          if (r_cnt == 4'd0) begin
            r_state <= StDone;
            r_d     <= 4'b0000;
            r_done  <= 1'b1;
          end else begin
            r_cnt <= r_cnt - 4'd1;
          end
        end
        StDone: begin
          r_state <= StIdle;
          r_ready <= 1'b1;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
        end
        default: begin
          // Unreachable encoding: recover to a clean idle.
          r_state <= StIdle;
          r_cnt   <= 4'd0;
          r_y     <= 2'd0;
          r_ready <= 1'b1;
          r_d     <= 4'b0000;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
        end
      endcase
    end
  end

  assign ready = r_ready;
  assign D     = r_d;
  assign busy  = r_busy;
  assign done  = r_done;

endmodule
